// File: rtl/dpram_fifo_pkg.sv
// Shared defaults for the dpram-backed stream FIFO.
package dpram_fifo_pkg;

  // Default geometry: 32-deep RAM of 16-bit words.
  localparam int unsigned DefAw = 5;
  localparam int unsigned DefDw = 16;

endpackage

// File: rtl/dpram_fifo_dpram.sv
// Simple dual-port RAM with a registered read address and a combinational data-out.
// No storage reset; contents after reset are don't-care.
module dpram #(
  parameter int unsigned aw = 5,
  parameter int unsigned dw = 16
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic          rce,
  input  logic          oe,
  input  logic [aw-1:0] ra,
  output logic [dw-1:0] dout,
  input  logic          wclk,
  input  logic          wrst,
  input  logic          wce,
  input  logic          we,
  input  logic [aw-1:0] wa,
  input  logic [dw-1:0] di
);

  logic [dw-1:0] mem [2**aw];
  logic [aw-1:0] ra_q;

  // Capture the read address; data follows combinationally from the array.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      ra_q <= '0;
    end else if (rce) begin
      ra_q <= ra;
    end
  end

  // Write port.
  always_ff @(posedge wclk) begin
    if (!wrst && wce && we) begin
      mem[wa] <= di;
    end
  end

  assign dout = oe ? mem[ra_q] : '0;

endmodule

// File: rtl/dpram_fifo.sv
// Single-clock first-word-fall-through stream FIFO built around one dpram.
// A 1-entry output stage hides the RAM's registered read address; capacity is DEPTH+1.
module dpram_fifo
  import dpram_fifo_pkg::*;
#(
  parameter int unsigned AW = DefAw,
  parameter int unsigned DW = DefDw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW+1:0] level
);

  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [PW-1:0] FullCnt = {1'b1, {AW{1'b0}}};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] ram_cnt;
  logic [DW-1:0] rdata;
  logic          push;
  logic          pop;
  logic          load;

  assign ram_cnt = wr_ptr - rd_ptr;
  assign s_ready = (ram_cnt != FullCnt);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;
  assign load    = (ram_cnt != '0) & (~m_valid | m_ready);
  assign level   = {1'b0, ram_cnt} + {{PW{1'b0}}, m_valid};

  // Next read pointer drives the RAM read address so its registered address tracks rd_ptr.
  always_comb begin
    rd_ptr_nxt = rd_ptr;
    if (!rst_n || clr) begin
      rd_ptr_nxt = '0;
    end else if (load) begin
      rd_ptr_nxt = rd_ptr + PtrOne;
    end
  end

  // Pointers and output stage; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    rd_ptr <= rd_ptr_nxt;
    if (!rst_n) begin
      wr_ptr  <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (clr) begin
      wr_ptr  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PtrOne;
      end
      if (load) begin
        m_data  <= rdata;
        m_valid <= 1'b1;
      end else if (pop) begin
        m_valid <= 1'b0;
      end
    end
  end

  dpram #(
    .aw(AW),
    .dw(DW)
  ) u_ram (
    .rclk (clk),
    .rrst (1'b0),
    .rce  (1'b1),
    .oe   (1'b1),
    .ra   (rd_ptr_nxt[AW-1:0]),
    .dout (rdata),
    .wclk (clk),
    .wrst (1'b0),
    .wce  (1'b1),
    .we   (push),
    .wa   (wr_ptr[AW-1:0]),
    .di   (s_data)
  );

endmodule
